rgb_frame_sender: RTL and testbench
===================================

Name: rgb_frame_sender

Overview:
- Stream source driving the filter's input pixel port: i_rgb_vld/i_rgb_data out, i_rgb_busy back.
- On a start pulse, reads one IMG_W x IMG_H frame of 24-bit RGB pixels in raster order from a synchronous-read pixel memory and emits them on the busy/vld point-to-point handshake.
- Sits between the frame buffer and the filter input.
- Contains a 2-entry output buffer so it sustains 1 pixel/cycle and never drops a pixel under back-pressure.

Parameters:
- IMG_W, 256, pixels per line (>=1).
- IMG_H, 256, lines per frame (>=1).
- ADDR_W, 16, memory address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle frame start request, sampled only in IDLE.
- o_active  out  1  high from the cycle after start is accepted until the cycle o_done pulses.
- o_done  out  1  one-cycle pulse after the last pixel has transferred.
- o_mem_rd  out  1  memory read enable.
- o_mem_addr  out  ADDR_W  linear pixel address, y*IMG_W+x.
- i_mem_data  in  24  read data, valid in the cycle after o_mem_rd=1 (fixed 1-cycle latency).
- o_rgb_vld  out  1  pixel valid toward the filter.
- o_rgb_data  out  24  pixel {R[23:16],G[15:8],B[7:0]}.
- i_rgb_busy  in  1  consumer busy (from the filter's i_rgb_busy output).

Behaviour:
- Reset (async, i_rst=0): all outputs are 0, FSM goes to IDLE, counters and buffer are cleared, and any in-flight read is discarded. Deassertion of reset is synchronised to i_clk.
- Transfer rule: a pixel moves on a rising edge with o_rgb_vld=1 and i_rgb_busy=0.
  - While o_rgb_vld=1 and i_rgb_busy=1, o_rgb_data holds stable.
  - o_rgb_vld never drops without a transfer.
  - o_rgb_data is 0 when o_rgb_vld=0.
- FSM states:
  - IDLE: i_start=1 -> FETCH. o_active rises the next cycle and rd_addr is set to 0.
  - FETCH: issues reads. After the read of address IMG_W*IMG_H-1 is issued -> DRAIN.
  - DRAIN: no reads. When the buffer is empty, no read is in flight, and the last pixel transferred -> DONE.
  - DONE: o_done=1 and o_active=0 for exactly one cycle -> IDLE.
- i_start in any state other than IDLE is ignored; no queuing.
- i_start sampled in the DONE cycle is also ignored. A new start is accepted from the first IDLE cycle.
- Read issue: o_mem_rd=1 in FETCH only when (buffer occupancy + in-flight reads) < 2, taking the post-edge view that counts a transfer popping in this same cycle.
  - o_mem_addr increments by 1 after each issued read.
  - No read is issued past IMG_W*IMG_H-1.
- Capture: i_mem_data is written into the buffer on the edge ending the cycle after the read.
  - The buffer head drives o_rgb_data.
  - Simultaneous push and pop is allowed in the same cycle; occupancy is unchanged.
  - Overflow is impossible by the credit rule. A push to a full buffer is a design error; the bench asserts it never happens.
- Latency, with i_start=1 in IDLE at cycle 0:
  - Cycle 1: o_mem_rd=1, addr 0.
  - Cycle 2: data arrives.
  - Cycle 3: o_rgb_vld=1 with pixel 0.
  - With i_rgb_busy held 0 after that, one pixel transfers every cycle with no bubbles.
- Pixel count: exactly IMG_W*IMG_H transfers per frame.
- o_done pulses in the cycle after the edge on which the final transfer occurs.
- IMG_W=IMG_H=1: a single read, a single transfer, then o_done.
- Reset mid-frame: the frame is abandoned immediately. After release the block is in IDLE and waits for a new i_start; it never resumes.

Test Plan:
- Basic frame: IMG_W=4, IMG_H=2, mem[a]=a*0x010203, i_rgb_busy=0, start at cycle 0 -> vld high cycles 3..10 with data 0x000000,0x010203,...,0x070E15; o_done at cycle 11; o_active cycles 1..10.
- Stall: busy=1 during cycles 4..7 of the basic frame -> pixel 1 held stable with vld=1 through cycle 7 and transfers at cycle 8; at most 2 reads outstanding+buffered; 8 transfers total, in order, no duplicates.
- Random back-pressure: busy random at 50% on a 16x16 frame -> the 256 pixels received equal mem[0..255] in order; o_done exactly once; the no-overflow assertion holds.
- Start ignored: pulse i_start again during FETCH, DRAIN and the DONE cycle -> no extra reads, no address reset, one o_done; a start one cycle after o_done begins a new frame from addr 0.
- Reset mid-frame: assert i_rst=0 asynchronously after 3 transfers -> vld, mem_rd, active and done drop to 0 without waiting for a clock; after release no activity until i_start, then a full frame from addr 0.
- Degenerate 1x1 frame: start -> one read of addr 0, one transfer at cycle 3, o_done at cycle 4.

Source files
------------

// File: rtl/rgb_frame_sender.sv
// ---------------------------------------------------------------------------
// rgb_frame_sender
//   Reads one IMG_W x IMG_H frame of 24-bit RGB pixels in raster order from a
//   synchronous-read pixel memory and streams it to the filter input over a
//   busy/vld handshake. A 2-entry output buffer with credit-based read issue
//   sustains one pixel per cycle and never drops a pixel under back-pressure.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-low reset (release synchronised to i_clk)
//   i_start     one-cycle frame start request, only honoured in IDLE
//   o_active    high while a frame is being fetched or drained
//   o_done      one-cycle pulse after the final pixel has transferred
//   o_mem_rd    pixel memory read enable
//   o_mem_addr  linear pixel address y*IMG_W+x
//   i_mem_data  read data, valid the cycle after o_mem_rd
//   o_rgb_vld   pixel valid toward the filter
//   o_rgb_data  pixel {R,G,B}, zero whenever o_rgb_vld is low
//   i_rgb_busy  consumer busy; a pixel moves when vld=1 and busy=0
// ---------------------------------------------------------------------------
module rgb_frame_sender #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_active,
  output logic              o_done,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [23:0]       i_mem_data,
  output logic              o_rgb_vld,
  output logic [23:0]       o_rgb_data,
  input  logic              i_rgb_busy
);

  localparam int                DATA_W    = 24;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reset assertion is immediate; release is delayed by two clock edges so
  // every flop leaves reset on the same edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_p0;
  logic                vld_p1;
  logic [1:0]          occ_p2;
  logic [DATA_W-1:0]   head_p2, tail_p2;
  logic                pop;
  logic [2:0]          occ_after;

  assign pop = (occ_p2 != 2'd0) && !i_rgb_busy;

  // Occupancy as it will stand after this edge: the in-flight read lands,
  // and a transfer this cycle frees its slot. Reads are issued against it.
  assign occ_after = {1'b0, occ_p2} + {2'b00, vld_p1} - {2'b00, pop};

  always_comb begin
    state_nxt = state;
    rd_p0     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = FETCH;
      end
      FETCH: begin
        rd_p0 = (occ_after < 3'd2);
        if (rd_p0 && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (occ_after == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: read issue and address generation
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_addr <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && i_start) begin
        rd_addr <= '0;
      end else if (rd_p0 && (rd_addr != LAST_ADDR)) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // Stage p1: memory data returning this cycle
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= rd_p0;
  end

  // Stage p2: 2-entry output buffer, head drives the pixel port
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_p2  <= 2'd0;
      head_p2 <= '0;
      tail_p2 <= '0;
    end else begin
      occ_p2 <= occ_after[1:0];
      case ({vld_p1, pop})
        2'b10: begin
          if (occ_p2 == 2'd0) head_p2 <= i_mem_data;
          else                tail_p2 <= i_mem_data;
        end
        2'b01: begin
          head_p2 <= tail_p2;
          tail_p2 <= '0;
        end
        2'b11: begin
          if (occ_p2 == 2'd1) begin
            head_p2 <= i_mem_data;
          end else begin
            head_p2 <= tail_p2;
            tail_p2 <= i_mem_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_rgb_vld  = (occ_p2 != 2'd0);
  assign o_rgb_data = o_rgb_vld ? head_p2 : '0;
  assign o_mem_rd   = rd_p0;
  assign o_mem_addr = rd_addr;
  assign o_active   = (state == FETCH) || (state == DRAIN);
  assign o_done     = (state == DONE);

endmodule

// File: tb/tb_rgb_frame_sender.sv
// ---------------------------------------------------------------------------
// tb_rgb_frame_sender
//   Three instances: A (4x2) for basic, stall, start-ignore and mid-frame
//   reset; B (16x16) under random back-pressure; C (1x1) degenerate frame.
//   Only one instance is active at a time, so one scoreboard queue serves all.
// ---------------------------------------------------------------------------
module tb_rgb_frame_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start  [3];
  logic        busy   [3];
  logic        act    [3];
  logic        done   [3];
  logic        mem_rd [3];
  logic        vld    [3];
  logic [15:0] addr   [3];
  logic [23:0] mem_q  [3];
  logic [23:0] data   [3];

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [23:0] sbq [$];
  logic [23:0] mon_exp;

  int reads    [3] = '{default: 0};
  int xfers    [3] = '{default: 0};
  int done_cnt [3] = '{default: 0};
  int done_cyc [3] = '{default: 0};
  int vld_rise [3] = '{default: 0};
  int last_vld [3] = '{default: 0};
  int act_rise [3] = '{default: 0};
  int last_act [3] = '{default: 0};
  int rd_cyc   [3] = '{default: 0};
  int last_xfr [3] = '{default: 0};
  int outc     [3] = '{default: 0};
  int max_out  [3] = '{default: 0};
  int hold_err [3] = '{default: 0};
  int zero_err [3] = '{default: 0};
  int addr_err [3] = '{default: 0};
  int exp_addr [3] = '{default: 0};
  logic        prev_vld  [3];
  logic        prev_act  [3];
  logic        hold_pend [3];
  logic [23:0] hold_data [3];
  int xc [0:63];

  logic [23:0] basic_px [8] = '{24'h000000, 24'h010203, 24'h020406, 24'h030609,
                                24'h04080C, 24'h050A0F, 24'h060C12, 24'h070E15};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb_frame_sender #(.IMG_W(4), .IMG_H(2), .ADDR_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_start(start[0]), .o_active(act[0]),
    .o_done(done[0]), .o_mem_rd(mem_rd[0]), .o_mem_addr(addr[0]),
    .i_mem_data(mem_q[0]), .o_rgb_vld(vld[0]), .o_rgb_data(data[0]),
    .i_rgb_busy(busy[0]));

  rgb_frame_sender #(.IMG_W(16), .IMG_H(16), .ADDR_W(16)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_start(start[1]), .o_active(act[1]),
    .o_done(done[1]), .o_mem_rd(mem_rd[1]), .o_mem_addr(addr[1]),
    .i_mem_data(mem_q[1]), .o_rgb_vld(vld[1]), .o_rgb_data(data[1]),
    .i_rgb_busy(busy[1]));

  rgb_frame_sender #(.IMG_W(1), .IMG_H(1), .ADDR_W(16)) dut_c (
    .i_clk(clk), .i_rst(rst_n), .i_start(start[2]), .o_active(act[2]),
    .o_done(done[2]), .o_mem_rd(mem_rd[2]), .o_mem_addr(addr[2]),
    .i_mem_data(mem_q[2]), .o_rgb_vld(vld[2]), .o_rgb_data(data[2]),
    .i_rgb_busy(busy[2]));

  // Pixel memory contents: instance A holds a*0x010203, B and C xor 0x5A5A5A.
  function automatic logic [23:0] memf(input int g, input logic [15:0] a);
    logic [31:0] p;
    p = {16'd0, a} * 32'h0001_0203;
    return (g == 0) ? p[23:0] : (p[23:0] ^ 24'h5A5A5A);
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (mem_rd[g]) mem_q[g] <= memf(g, addr[g]);
    end
  end

  task automatic check(input string nm, input longint actual, input longint expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, actual, expected);
  endtask

  task automatic check_le(input string nm, input int actual, input int limit);
    total_cnt++;
    if (actual <= limit) pass_cnt++;
    else $display("FAIL %s: got %0d, limit %0d", nm, actual, limit);
  endtask

  task automatic fail(input string nm, input string why);
    total_cnt++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!vld[g] && (data[g] != 24'h0)) zero_err[g]++;
      if (!rst_n) begin
        outc[g]      = 0;
        hold_pend[g] = 1'b0;
      end else begin
        if (hold_pend[g] && !(vld[g] && (data[g] == hold_data[g]))) hold_err[g]++;
        hold_pend[g] = vld[g] && busy[g];
        hold_data[g] = data[g];
        if (vld[g] && !prev_vld[g]) vld_rise[g] = cyc;
        if (vld[g]) last_vld[g] = cyc;
        if (act[g] && !prev_act[g]) begin
          act_rise[g] = cyc;
          exp_addr[g] = 0;
        end
        if (act[g]) last_act[g] = cyc;
        if (done[g]) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
        end
        if (mem_rd[g]) begin
          if (addr[g] != 16'(exp_addr[g])) addr_err[g]++;
          exp_addr[g]++;
          reads[g]++;
          outc[g]++;
          rd_cyc[g] = cyc;
        end
        if (vld[g] && !busy[g]) begin
          if (g == 0 && xfers[0] < 64) xc[xfers[0]] = cyc;
          xfers[g]++;
          outc[g]--;
          last_xfr[g] = cyc;
          if (sbq.size() == 0) begin
            fail($sformatf("pixel%0d", g), $sformatf("unexpected pixel 0x%0h", data[g]));
          end else begin
            mon_exp = sbq.pop_front();
            check($sformatf("pixel%0d", g), data[g], mon_exp);
          end
        end
        if (outc[g] > max_out[g]) max_out[g] = outc[g];
      end
      prev_vld[g] = vld[g];
      prev_act[g] = act[g];
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input int g, output int s);
    start[g] = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target, input int limit);
    int n;
    n = 0;
    while (done_cnt[g] < target && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt[g] < target) fail($sformatf("done_timeout%0d", g), "o_done never pulsed");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int s, s2, r0, x0, d0, r1, n;
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      busy[g]  = 1'b0;
    end
    #2 rst_n = 1'b0;
    #2;
    check("reset_vld_a", vld[0], 0);
    check("reset_rd_a", mem_rd[0], 0);
    check("reset_active_a", act[0], 0);
    check("reset_done_a", done[0], 0);
    check("reset_data_a", data[0], 0);
    check("reset_addr_a", addr[0], 0);
    check("reset_vld_b", vld[1], 0);
    check("reset_vld_c", vld[2], 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Basic 4x2 frame, no back-pressure
    r0 = reads[0]; x0 = xfers[0]; d0 = done_cnt[0];
    for (int i = 0; i < 8; i++) sbq.push_back(basic_px[i]);
    launch(0, s);
    wait_done(0, d0 + 1, 40);
    check("basic_vld_first", vld_rise[0] - s, 3);
    check("basic_vld_last", last_vld[0] - s, 10);
    check("basic_done_cyc", done_cyc[0] - s, 11);
    check("basic_active_first", act_rise[0] - s, 1);
    check("basic_active_last", last_act[0] - s, 10);
    check("basic_reads", reads[0] - r0, 8);
    check("basic_xfers", xfers[0] - x0, 8);
    check("basic_done_cnt", done_cnt[0] - d0, 1);
    check("basic_queue_left", sbq.size(), 0);

    // Stall: busy during cycles 4..7
    r0 = reads[0]; x0 = xfers[0]; d0 = done_cnt[0];
    for (int i = 0; i < 8; i++) sbq.push_back(basic_px[i]);
    launch(0, s);
    goto(s + 4);
    busy[0] = 1'b1;
    goto(s + 8);
    busy[0] = 1'b0;
    wait_done(0, d0 + 1, 40);
    check("stall_px0_cyc", xc[x0] - s, 3);
    check("stall_px1_cyc", xc[x0 + 1] - s, 8);
    check("stall_vld_last", last_vld[0] - s, 14);
    check("stall_done_cyc", done_cyc[0] - s, 15);
    check("stall_hold_err", hold_err[0], 0);
    check_le("stall_outstanding", max_out[0], 2);
    check("stall_reads", reads[0] - r0, 8);
    check("stall_xfers", xfers[0] - x0, 8);
    check("stall_queue_left", sbq.size(), 0);

    // Start ignored in FETCH, DRAIN and DONE; accepted in first IDLE cycle
    r0 = reads[0]; x0 = xfers[0]; d0 = done_cnt[0];
    for (int i = 0; i < 8; i++) sbq.push_back(basic_px[i]);
    launch(0, s);
    goto(s + 2);  start[0] = 1'b1;
    goto(s + 3);  start[0] = 1'b0;
    goto(s + 9);  start[0] = 1'b1;
    goto(s + 10); start[0] = 1'b0;
    goto(s + 11); start[0] = 1'b1;
    check("ign_done_in_cycle11", done[0], 1);
    goto(s + 12);
    for (int i = 0; i < 8; i++) sbq.push_back(basic_px[i]);
    goto(s + 13); start[0] = 1'b0;
    wait_done(0, d0 + 2, 60);
    check("ign_done_cnt", done_cnt[0] - d0, 2);
    check("ign_done2_cyc", done_cyc[0] - s, 23);
    check("ign_reads", reads[0] - r0, 16);
    check("ign_xfers", xfers[0] - x0, 16);
    check("ign_addr_err", addr_err[0], 0);
    check("ign_queue_left", sbq.size(), 0);

    // Reset mid-frame after 3 transfers
    x0 = xfers[0];
    for (int i = 0; i < 8; i++) sbq.push_back(basic_px[i]);
    launch(0, s);
    goto(s + 6);
    #2;
    check("mid_pre_vld", vld[0], 1);
    check("mid_pre_rd", mem_rd[0], 1);
    check("mid_pre_xfers", xfers[0] - x0, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", vld[0], 0);
    check("mid_rst_rd", mem_rd[0], 0);
    check("mid_rst_active", act[0], 0);
    check("mid_rst_done", done[0], 0);
    check("mid_rst_data", data[0], 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    r1 = reads[0]; d0 = done_cnt[0]; x0 = xfers[0];
    repeat (6) @(posedge clk);
    #1;
    check("mid_idle_reads", reads[0] - r1, 0);
    check("mid_idle_xfers", xfers[0] - x0, 0);
    check("mid_idle_active", act[0], 0);
    r0 = reads[0];
    for (int i = 0; i < 8; i++) sbq.push_back(basic_px[i]);
    launch(0, s2);
    wait_done(0, d0 + 1, 40);
    check("mid_new_done_cyc", done_cyc[0] - s2, 11);
    check("mid_new_reads", reads[0] - r0, 8);
    check("mid_new_done_cnt", done_cnt[0] - d0, 1);
    check("mid_queue_left", sbq.size(), 0);

    // Random back-pressure on a 16x16 frame
    for (int a = 0; a < 256; a++) sbq.push_back(memf(1, 16'(a)));
    launch(1, s);
    n = 0;
    while (done_cnt[1] < 1 && n < 3000) begin
      busy[1] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    busy[1] = 1'b0;
    if (done_cnt[1] < 1) fail("rand_timeout", "o_done never pulsed");
    repeat (5) @(posedge clk);
    #1;
    check("rand_done_cnt", done_cnt[1], 1);
    check("rand_reads", reads[1], 256);
    check("rand_xfers", xfers[1], 256);
    check("rand_queue_left", sbq.size(), 0);
    check("rand_hold_err", hold_err[1], 0);
    check("rand_addr_err", addr_err[1], 0);
    check_le("rand_outstanding", max_out[1], 2);

    // Degenerate 1x1 frame
    sbq.push_back(24'h5A5A5A);
    launch(2, s);
    wait_done(2, 1, 20);
    check("one_reads", reads[2], 1);
    check("one_rd_cyc", rd_cyc[2] - s, 1);
    check("one_xfers", xfers[2], 1);
    check("one_xfer_cyc", last_xfr[2] - s, 3);
    check("one_done_cyc", done_cyc[2] - s, 4);
    check("one_done_cnt", done_cnt[2], 1);
    check("one_queue_left", sbq.size(), 0);

    for (int g = 0; g < 3; g++) begin
      check($sformatf("zero_when_idle%0d", g), zero_err[g], 0);
      check($sformatf("addr_order%0d", g), addr_err[g], 0);
      check($sformatf("hold_stable%0d", g), hold_err[g], 0);
      check_le($sformatf("no_overflow%0d", g), max_out[g], 2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
